// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction controller: FSM state encoding,
// operation codes and result status codes.
package atm_pkg;

  localparam int unsigned ST_W = 3;
  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    StIdle, StScanSrc, StWaitPin, StPinChk, StMenu, StExec, StScanDst, StEject
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OpDep  = 3'd0,
    OpWdr  = 3'd1,
    OpBal  = 3'd2,
    OpXfr  = 3'd3,
    OpExit = 3'd4
  } op_e;

  typedef enum logic [ST_W-1:0] {
    StsOk      = 3'd0,
    StsNoCard  = 3'd1,
    StsBadPin  = 3'd2,
    StsLocked  = 3'd3,
    StsNoFunds = 3'd4,
    StsBadAmt  = 3'd5,
    StsBadDst  = 3'd6,
    StsTimeout = 3'd7
  } status_e;

endpackage

// File: rtl/atm_acct_scan.sv
// Sequential linear search over the account table, one entry per cycle from
// index 0. Shared by the source-card and transfer-destination lookups.
//   clk, rst   : clock, synchronous active-high reset
//   start      : restart the search at index 0 (entry 0 is compared next cycle)
//   key        : account number being searched for
//   accts      : account numbers of all table entries
//   valid      : per-entry valid bits
//   hit, miss  : single-cycle result flags while the search is active
//   idx        : index of the entry currently compared (the hit index on hit)
module atm_acct_scan #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned NUM_ACCTS = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_ACCTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DATA_W-1:0]                key,
  input  logic [NUM_ACCTS-1:0][DATA_W-1:0] accts,
  input  logic [NUM_ACCTS-1:0]             valid,
  output logic                             hit,
  output logic                             miss,
  output logic [IDX_W-1:0]                 idx
);

  logic             active_q;
  logic [IDX_W-1:0] ptr_q;
  logic             match;

  assign idx = ptr_q;

  always_comb begin
    match = valid[ptr_q] && (accts[ptr_q] == key);
    hit   = active_q && match;
    // Scanning upward and stopping on the first match makes the lowest index win.
    miss  = active_q && !match && (ptr_q == IDX_W'(NUM_ACCTS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ptr_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      ptr_q    <= '0;
    end else if (active_q) begin
      if (hit || miss) active_q <= 1'b0;
      else             ptr_q    <= ptr_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/atm_core_param.sv
// ATM transaction controller: card lookup, PIN check with retry lockout and
// deposit / withdraw / balance / transfer against a register account table.
//   clk, rst                  : clock, synchronous active-high reset
//   init_we/idx/acct/pin/bal  : table load port, honoured only while idle
//   card_valid/account_number : card insertion strobe and card number
//   pin_valid/pin             : PIN entry strobe and value
//   op_valid/operation/amount/dst_account : menu operation strobe and operands
//   busy                      : session in progress (any state but idle)
//   done/status               : one-cycle result pulse and its code
//   final_balance             : source balance after the last successful op
//   final_dst_balance         : destination balance after the last successful transfer
// A correct PIN also produces a done pulse with status OK.
module atm_core_param
  import atm_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned NUM_ACCTS   = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IDX_W      = $clog2(NUM_ACCTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_we,
  input  logic [IDX_W-1:0]  init_idx,
  input  logic [DATA_W-1:0] init_acct,
  input  logic [DATA_W-1:0] init_pin,
  input  logic [DATA_W-1:0] init_bal,
  input  logic              card_valid,
  input  logic [DATA_W-1:0] account_number,
  input  logic              pin_valid,
  input  logic [DATA_W-1:0] pin,
  input  logic              op_valid,
  input  logic [2:0]        operation,
  input  logic [DATA_W-1:0] amount,
  input  logic [DATA_W-1:0] dst_account,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status,
  output logic [DATA_W-1:0] final_balance,
  output logic [DATA_W-1:0] final_dst_balance
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e state_q, state_d;

  logic [NUM_ACCTS-1:0][DATA_W-1:0] acct_q, pin_tbl_q, bal_q;
  logic [NUM_ACCTS-1:0][TRY_W-1:0]  tries_q;
  logic [NUM_ACCTS-1:0]             valid_q, lock_q;

  logic [DATA_W-1:0] card_q, pin_in_q, amt_q, dst_q;
  op_e               op_q;
  logic [IDX_W-1:0]  src_idx_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              done_q;
  status_e           status_q;
  logic [DATA_W-1:0] fbal_q, fdbal_q;

  logic              scan_start, scan_hit, scan_miss;
  logic [IDX_W-1:0]  scan_idx;
  logic [DATA_W-1:0] scan_key;

  logic [DATA_W-1:0] src_bal, dst_bal;
  logic [DATA_W:0]   dep_sum, xfr_sum;
  logic [TRY_W-1:0]  tries_inc;
  logic              pin_ok, tmo_hit;

  // Result controls produced alongside the next state.
  logic              fin, set_fbal, wr_src, wr_dst, pin_pass, pin_fail, lock_set;
  status_e           fin_st;
  logic [DATA_W-1:0] fbal_new, fdbal_new;

  assign src_bal   = bal_q[src_idx_q];
  assign dst_bal   = bal_q[scan_idx];
  assign dep_sum   = {1'b0, src_bal} + {1'b0, amt_q};
  assign xfr_sum   = {1'b0, dst_bal} + {1'b0, amt_q};
  assign pin_ok    = (pin_tbl_q[src_idx_q] == pin_in_q);
  assign tries_inc = tries_q[src_idx_q] + TRY_W'(1);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  atm_acct_scan #(
    .DATA_W   (DATA_W),
    .NUM_ACCTS(NUM_ACCTS)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .start(scan_start),
    .key  (scan_key),
    .accts(acct_q),
    .valid(valid_q),
    .hit  (scan_hit),
    .miss (scan_miss),
    .idx  (scan_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state and per-cycle result decisions.
  always_comb begin
    state_d   = state_q;
    fin       = 1'b0;
    fin_st    = StsOk;
    set_fbal  = 1'b0;
    wr_src    = 1'b0;
    wr_dst    = 1'b0;
    pin_pass  = 1'b0;
    pin_fail  = 1'b0;
    lock_set  = 1'b0;
    fbal_new  = src_bal;
    fdbal_new = dst_bal;
    unique case (state_q)
      StIdle: if (card_valid) state_d = StScanSrc;
      StScanSrc: begin
        if (scan_hit) begin
          if (lock_q[scan_idx]) begin
            state_d = StEject; fin = 1'b1; fin_st = StsLocked;
          end else begin
            state_d = StWaitPin;
          end
        end else if (scan_miss) begin
          state_d = StEject; fin = 1'b1; fin_st = StsNoCard;
        end
      end
      StWaitPin: begin
        if (pin_valid) state_d = StPinChk;
        else if (tmo_hit) begin
          state_d = StEject; fin = 1'b1; fin_st = StsTimeout;
        end
      end
      StPinChk: begin
        fin = 1'b1;
        if (pin_ok) begin
          pin_pass = 1'b1;
          state_d  = StMenu;
        end else begin
          pin_fail = 1'b1;
          if (32'(tries_inc) >= MAX_TRIES) begin
            lock_set = 1'b1; state_d = StEject; fin_st = StsLocked;
          end else begin
            state_d = StWaitPin; fin_st = StsBadPin;
          end
        end
      end
      StMenu: begin
        if (op_valid && (operation <= OpExit)) begin
          if (operation == OpExit) begin
            state_d = StEject; fin = 1'b1;
          end else begin
            state_d = StExec;
          end
        end else if (tmo_hit) begin
          state_d = StEject; fin = 1'b1; fin_st = StsTimeout;
        end
      end
      StExec: begin
        state_d = StMenu;
        fin     = 1'b1;
        case (op_q)
          OpDep: begin
            if (amt_q == '0 || dep_sum[DATA_W]) fin_st = StsBadAmt;
            else begin
              fbal_new = dep_sum[DATA_W-1:0]; wr_src = 1'b1; set_fbal = 1'b1;
            end
          end
          OpWdr: begin
            if (amt_q == '0)          fin_st = StsBadAmt;
            else if (amt_q > src_bal) fin_st = StsNoFunds;
            else begin
              fbal_new = src_bal - amt_q; wr_src = 1'b1; set_fbal = 1'b1;
            end
          end
          OpXfr: begin
            if (amt_q == '0)          fin_st = StsBadAmt;
            else if (amt_q > src_bal) fin_st = StsNoFunds;
            else begin
              fin = 1'b0; state_d = StScanDst;
            end
          end
          default: set_fbal = 1'b1;  // balance enquiry
        endcase
      end
      StScanDst: begin
        if (scan_hit || scan_miss) begin
          state_d = StMenu;
          fin     = 1'b1;
          if (scan_miss || scan_idx == src_idx_q) fin_st = StsBadDst;
          else if (xfr_sum[DATA_W])                fin_st = StsBadAmt;
          else begin
            // Source and destination are committed on the same edge.
            fbal_new  = src_bal - amt_q;
            fdbal_new = xfr_sum[DATA_W-1:0];
            wr_src    = 1'b1;
            wr_dst    = 1'b1;
            set_fbal  = 1'b1;
          end
        end
      end
      StEject: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and scan control.
  always_comb begin
    busy       = (state_q != StIdle);
    scan_start = (state_q == StIdle && card_valid) ||
                 (state_q == StExec && state_d == StScanDst);
    scan_key   = (state_q == StScanDst) ? dst_q : card_q;
  end

  assign done              = done_q;
  assign status            = status_q;
  assign final_balance     = fbal_q;
  assign final_dst_balance = fdbal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acct_q    <= '0;
      pin_tbl_q <= '0;
      bal_q     <= '0;
      tries_q   <= '0;
      valid_q   <= '0;
      lock_q    <= '0;
      card_q    <= '0;
      pin_in_q  <= '0;
      amt_q     <= '0;
      dst_q     <= '0;
      op_q      <= OpDep;
      src_idx_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      status_q  <= StsOk;
      fbal_q    <= '0;
      fdbal_q   <= '0;
    end else begin
      if (state_q == StIdle && init_we && 32'(init_idx) < NUM_ACCTS) begin
        acct_q[init_idx]    <= init_acct;
        pin_tbl_q[init_idx] <= init_pin;
        bal_q[init_idx]     <= init_bal;
        valid_q[init_idx]   <= 1'b1;
        tries_q[init_idx]   <= '0;
        lock_q[init_idx]    <= 1'b0;
      end
      if (state_q == StIdle && card_valid)    card_q    <= account_number;
      if (state_q == StScanSrc && scan_hit)   src_idx_q <= scan_idx;
      if (state_q == StWaitPin && pin_valid)  pin_in_q  <= pin;
      if (state_q == StMenu && op_valid) begin
        op_q  <= op_e'(operation);
        amt_q <= amount;
        dst_q <= dst_account;
      end
      if (pin_pass) tries_q[src_idx_q] <= '0;
      if (pin_fail) tries_q[src_idx_q] <= tries_inc;
      if (lock_set) lock_q[src_idx_q]  <= 1'b1;
      if (wr_src)   bal_q[src_idx_q]   <= fbal_new;
      if (wr_dst)   bal_q[scan_idx]    <= fdbal_new;

      if (strobe_any() || state_d != state_q || !(state_q inside {StWaitPin, StMenu}))
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TMO_W'(1);

      done_q <= fin;
      if (fin)      status_q <= fin_st;
      if (set_fbal) fbal_q   <= fbal_new;
      if (wr_dst)   fdbal_q  <= fdbal_new;
    end
  end

  function automatic logic strobe_any();
    return card_valid || pin_valid || op_valid;
  endfunction

endmodule

// File: tb/tb_atm_core_param.sv
// Directed bench for atm_core_param: stimulus pushes hand-computed results
// into a queue; a negedge monitor pops and compares on every done pulse.
module tb_atm_core_param;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_we;
  logic [IDX_W-1:0]  init_idx;
  logic [DATA_W-1:0] init_acct, init_pin, init_bal;
  logic              card_valid, pin_valid, op_valid;
  logic [DATA_W-1:0] account_number, pin, amount, dst_account;
  logic [2:0]        operation;
  logic              busy, done;
  logic [2:0]        status;
  logic [DATA_W-1:0] final_balance, final_dst_balance;

  atm_core_param #(
    .DATA_W     (12),
    .NUM_ACCTS  (4),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .init_we          (init_we),
    .init_idx         (init_idx),
    .init_acct        (init_acct),
    .init_pin         (init_pin),
    .init_bal         (init_bal),
    .card_valid       (card_valid),
    .account_number   (account_number),
    .pin_valid        (pin_valid),
    .pin              (pin),
    .op_valid         (op_valid),
    .operation        (operation),
    .amount           (amount),
    .dst_account      (dst_account),
    .busy             (busy),
    .done             (done),
    .status           (status),
    .final_balance    (final_balance),
    .final_dst_balance(final_dst_balance)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        st;
    logic [DATA_W-1:0] bal;
    logic [DATA_W-1:0] dbal;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] OK = 3'd0, NO_CARD = 3'd1, BAD_PIN = 3'd2, LOCKED = 3'd3,
                         NO_FUNDS = 3'd4, BAD_AMT = 3'd5, BAD_DST = 3'd6, TIMEOUT = 3'd7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got status %0d, expected no done at %0t", status, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("status", 32'(status), 32'(e.st));
        check("final_balance", 32'(final_balance), 32'(e.bal));
        check("final_dst_balance", 32'(final_dst_balance), 32'(e.dbal));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [2:0] st, input logic [DATA_W-1:0] b,
                            input logic [DATA_W-1:0] d);
    exp_t e;
    e.st = st; e.bal = b; e.dbal = d;
    q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, expected 0",
               name, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic card(input logic [DATA_W-1:0] a);
    account_number = a; card_valid = 1'b1;
    tick(1);
    card_valid = 1'b0;
  endtask

  task automatic pin_in(input logic [DATA_W-1:0] p);
    pin = p; pin_valid = 1'b1;
    tick(1);
    pin_valid = 1'b0;
  endtask

  task automatic op(input logic [2:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    operation = o; amount = a; dst_account = d; op_valid = 1'b1;
    tick(1);
    op_valid = 1'b0;
  endtask

  task automatic load(input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] b);
    init_idx = i; init_acct = a; init_pin = p; init_bal = b; init_we = 1'b1;
    tick(1);
    init_we = 1'b0;
  endtask

  // Session step: issue one op and wait for its result.
  task automatic do_op(input string name, input logic [2:0] o, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [2:0] st,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] db);
    expect_res(st, b, db);
    op(o, a, d);
    drain(name, 40);
  endtask

  task automatic do_pin(input string name, input logic [DATA_W-1:0] p, input logic [2:0] st,
                        input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] db);
    expect_res(st, b, db);
    pin_in(p);
    drain(name, 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; init_we = 1'b0; init_idx = '0; init_acct = '0; init_pin = '0; init_bal = '0;
    card_valid = 1'b0; pin_valid = 1'b0; op_valid = 1'b0;
    account_number = '0; pin = '0; amount = '0; dst_account = '0; operation = '0;
    tick(3);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_status", 32'(status), 0);
    check("reset_final_balance", 32'(final_balance), 0);
    check("reset_final_dst_balance", 32'(final_dst_balance), 0);
    rst = 1'b0;
    tick(1);

    load(2'd0, 12'h101, 12'h111, 12'd100);
    load(2'd1, 12'h202, 12'h222, 12'd50);
    load(2'd2, 12'h303, 12'h333, 12'd10);
    load(2'd3, 12'h404, 12'h444, 12'd0);

    // Session 1: 0x101
    card(12'h101);
    tick(4);
    check("busy_in_session", 32'(busy), 1);
    do_pin("pin_ok_101", 12'h111, OK, 12'd0, 12'd0);
    do_op("deposit_20", 3'd0, 12'd20, 12'h0, OK, 12'd120, 12'd0);
    do_op("withdraw_121", 3'd1, 12'd121, 12'h0, NO_FUNDS, 12'd120, 12'd0);
    do_op("withdraw_120", 3'd1, 12'd120, 12'h0, OK, 12'd0, 12'd0);
    do_op("withdraw_0", 3'd1, 12'd0, 12'h0, BAD_AMT, 12'd0, 12'd0);
    op(3'd5, 12'd7, 12'h0);  // ignored: no done expected
    tick(4);
    do_op("balance_101", 3'd2, 12'd0, 12'h0, OK, 12'd0, 12'd0);
    do_op("exit_1", 3'd4, 12'd0, 12'h0, OK, 12'd0, 12'd0);
    tick(2);
    check("idle_after_exit", 32'(busy), 0);

    // Session 2: transfers from 0x202
    card(12'h202);
    tick(4);
    do_pin("pin_ok_202", 12'h222, OK, 12'd0, 12'd0);
    do_op("xfr_30", 3'd3, 12'd30, 12'h101, OK, 12'd20, 12'd30);
    do_op("xfr_bad_dst", 3'd3, 12'd5, 12'h999, BAD_DST, 12'd20, 12'd30);
    do_op("xfr_self", 3'd3, 12'd5, 12'h202, BAD_DST, 12'd20, 12'd30);
    do_op("xfr_no_funds", 3'd3, 12'd21, 12'h101, NO_FUNDS, 12'd20, 12'd30);
    do_op("exit_2", 3'd4, 12'd0, 12'h0, OK, 12'd20, 12'd30);
    tick(2);

    // Session 3: lockout of 0x202
    card(12'h202);
    tick(4);
    do_pin("bad_pin_1", 12'h000, BAD_PIN, 12'd20, 12'd30);
    do_pin("bad_pin_2", 12'h001, BAD_PIN, 12'd20, 12'd30);
    do_pin("bad_pin_3", 12'h002, LOCKED, 12'd20, 12'd30);
    tick(2);
    check("idle_after_lock", 32'(busy), 0);
    expect_res(LOCKED, 12'd20, 12'd30);
    card(12'h202);
    drain("reinsert_locked", 20);
    tick(2);

    // Session 4: unknown card
    expect_res(NO_CARD, 12'd20, 12'd30);
    card(12'h555);
    drain("unknown_card", 20);
    tick(2);

    // Session 5: 0x303 overflow boundaries then timeout
    card(12'h303);
    tick(5);
    do_pin("pin_ok_303", 12'h333, OK, 12'd20, 12'd30);
    do_op("deposit_overflow", 3'd0, 12'd4090, 12'h0, BAD_AMT, 12'd20, 12'd30);
    do_op("balance_303", 3'd2, 12'd0, 12'h0, OK, 12'd10, 12'd30);
    do_op("deposit_to_max", 3'd0, 12'd4085, 12'h0, OK, 12'd4095, 12'd30);
    expect_res(TIMEOUT, 12'd4095, 12'd30);
    drain("menu_timeout", 1200);
    tick(2);
    check("idle_after_timeout", 32'(busy), 0);

    // Session 6: destination overflow, amount == balance transfer, reset mid-scan
    card(12'h101);
    tick(4);
    do_pin("pin_ok_101b", 12'h111, OK, 12'd4095, 12'd30);
    do_op("xfr_dst_overflow", 3'd3, 12'd1, 12'h303, BAD_AMT, 12'd4095, 12'd30);
    do_op("xfr_25", 3'd3, 12'd25, 12'h404, OK, 12'd5, 12'd25);
    op(3'd3, 12'd5, 12'h404);
    tick(2);  // now in the destination scan
    check("busy_in_scan_dst", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(status), 0);
    check("rst_final_balance", 32'(final_balance), 0);
    check("rst_final_dst_balance", 32'(final_dst_balance), 0);
    @(posedge clk);
    #1;
    expect_res(NO_CARD, 12'd0, 12'd0);
    card(12'h101);
    drain("table_cleared", 20);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
